multiword_add_seq: RTL and testbench
====================================

Name: multiword_add_seq

Overview:
- Sequential multi-precision add/subtract engine built around the team's 32-bit combinational adder.
- Accepts operand word pairs LSW-first over a valid/ready stream and chains carry between words.
- Emits one registered result word per accepted pair, with final carry and signed-overflow flags on the last word.
- Sits directly upstream of the adder (drives data_1/data_2/carry_in) and consumes its sum/carry_out.

Parameters:
- DATA_WIDTH, 32, bits per word; the adder instance gets data_width = DATA_WIDTH-1 (MSB index).
- WORDS, 2, words per operation; legal range >= 1; operation width is WORDS*DATA_WIDTH.
- CNT_W, max(1,$clog2(WORDS)), word-index counter width (derived; not to be overridden).

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  engine can accept a pair.
- in_a  in  DATA_WIDTH  operand A word.
- in_b  in  DATA_WIDTH  operand B word.
- in_sub  in  1  1 = A-B, 0 = A+B; sampled only on the first word of an operation.
- out_valid  out  1  result word valid.
- out_ready  in  1  downstream accepts the result word.
- out_sum  out  DATA_WIDTH  result word.
- out_last  out  1  result word is the MSW of the operation.
- out_carry  out  1  final carry out, valid with out_last; in subtract mode 1 = no borrow. 0 when !out_last.
- out_ovf  out  1  signed overflow of the full-width result, valid with out_last. 0 when !out_last.
- busy  out  1  an operation is partially accepted (word index != 0).

Behaviour:
- Handshake rules:
  - Transfer occurs when valid && ready.
  - in_ready = !out_valid || out_ready (single-entry output register, pass-through on accept).
  - in_ready is combinational from out_ready only; there is no path from in_valid.
- Per accepted pair:
  - b_eff = sub ? ~in_b : in_b.
  - carry_in = (idx==0) ? in_sub : carry_reg.
  - sub_reg captures in_sub at idx==0; later words use sub_reg.
  - Adder outputs are registered into out_sum next edge (latency 1 cycle, throughput 1 word/cycle).
  - carry_reg <= carry_out.
  - idx increments, wrapping to 0 after WORDS-1.
- Last word (idx==WORDS-1):
  - out_last = 1 and out_carry = carry_out.
  - out_ovf = (in_a[MSB]==b_eff[MSB]) && (sum[MSB]!=in_a[MSB]).
- Edge cases:
  - WORDS=1: every word is both first and last; carry_reg is unused.
  - Output held: out_sum/out_last/out_carry/out_ovf remain stable while out_valid && !out_ready.
  - out_valid clears on accept unless a new pair is accepted the same cycle (simultaneous in/out transfer keeps out_valid=1 with new data).
  - in_sub changes mid-operation are ignored.
- Reset (async, any time including mid-operation) clears idx, carry_reg, sub_reg, out_valid, out_sum, out_last, out_carry, out_ovf and busy to 0. The partial operation is discarded; the next accepted pair is word 0.
- State machine: IDLE (idx==0, busy=0) -> RUN on first accept when WORDS>1. RUN -> IDLE on last-word accept. No other transitions.

Decomposition:
- Shared package (add_pkg):
  - default DATA_WIDTH and WORDS constants.
  - op encoding constants OP_ADD=0 and OP_SUB=1.
  - state enum IDLE/RUN.
- One sub-module: an adder32_bit instance performs the word add, with data_1=in_a, data_2=b_eff, carry_in as above.
- All sequencing, inversion and flag logic stays in multiword_add_seq.

Test Plan:
- WORDS=2 add: 0x00000000_FFFFFFFF + 0x00000000_00000001 -> out_sum 0x00000000 then 0x00000001 (last), out_carry=0, out_ovf=0.
- WORDS=2 add: 0xFFFFFFFF_FFFFFFFF + 0x00000000_00000001 -> 0x00000000, 0x00000000 (last), out_carry=1, out_ovf=0.
- WORDS=2 sub, in_sub=1 on word 0 only, 0 on word 1: 0 - 1 -> 0xFFFFFFFF, 0xFFFFFFFF (last), out_carry=0 (borrow), out_ovf=0.
- WORDS=2 signed overflow: 0x7FFFFFFF_FFFFFFFF + 1 -> 0x00000000, 0x80000000, out_ovf=1, out_carry=0.
- Backpressure: hold out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0, out_sum unchanged, no word lost or duplicated; back-to-back throughput 1/cycle when out_ready=1.
- Reset mid-operation: assert rst_n=0 after word 0 accepted -> all outputs 0 immediately, busy=0; next pair treated as word 0 (carry_in = in_sub).

Source files
------------

// File: rtl/add_pkg.sv
// Shared constants and types for the multi-word add/subtract engine.
package add_pkg;

    localparam int DEFAULT_DATA_WIDTH = 32;
    localparam int DEFAULT_WORDS      = 2;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } seq_state_t;

endpackage

// File: rtl/adder32_bit.sv
// Combinational word adder with carry in/out; data_width is the MSB index.
module adder32_bit #(
    parameter int data_width = 31
) (
    input  logic [data_width:0] data_1,
    input  logic [data_width:0] data_2,
    input  logic                carry_in,
    output logic [data_width:0] sum,
    output logic                carry_out
);

    logic [data_width+1:0] full;

    // Full-width add; the extra bit is the carry out.
    always_comb begin
        full = {1'b0, data_1} + {1'b0, data_2} + {{(data_width+1){1'b0}}, carry_in};
        sum       = full[data_width:0];
        carry_out = full[data_width+1];
    end

endmodule

// File: rtl/multiword_add_seq.sv
// Sequential multi-precision add/subtract: LSW-first word pairs, carry chained
// through a register, one registered result word per accepted pair.
module multiword_add_seq
    import add_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int WORDS      = DEFAULT_WORDS
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_a,
    input  logic [DATA_WIDTH-1:0] in_b,
    input  logic                  in_sub,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_sum,
    output logic                  out_last,
    output logic                  out_carry,
    output logic                  out_ovf,
    output logic                  busy
);

    localparam int CNT_W = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam int MSB   = DATA_WIDTH - 1;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WORDS - 1);

    seq_state_t            state;
    logic [CNT_W-1:0]      idx;
    logic                  carry_reg;
    logic                  sub_reg;

    logic                  accept;
    logic                  first_word;
    logic                  last_word;
    logic                  sub_eff;
    logic                  carry_in;
    logic [DATA_WIDTH-1:0] b_eff;
    logic [DATA_WIDTH-1:0] sum;
    logic                  carry_out;
    logic                  ovf;

    // Single-entry output register: accept whenever it is empty or draining.
    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;

    // Operand conditioning and flag derivation for the current word.
    always_comb begin
        first_word = (idx == '0);
        last_word  = (idx == LAST_IDX);
        sub_eff    = first_word ? in_sub : sub_reg;
        b_eff      = sub_eff ? ~in_b : in_b;
        carry_in   = first_word ? in_sub : carry_reg;
        ovf        = (in_a[MSB] == b_eff[MSB]) && (sum[MSB] != in_a[MSB]);
    end

    adder32_bit #(
        .data_width(DATA_WIDTH - 1)
    ) u_adder (
        .data_1   (in_a),
        .data_2   (b_eff),
        .carry_in (carry_in),
        .sum      (sum),
        .carry_out(carry_out)
    );

    // Sequencer FSM plus registered result word and flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            idx       <= '0;
            carry_reg <= 1'b0;
            sub_reg   <= 1'b0;
            busy      <= 1'b0;
            out_valid <= 1'b0;
            out_sum   <= '0;
            out_last  <= 1'b0;
            out_carry <= 1'b0;
            out_ovf   <= 1'b0;
        end else if (accept) begin
            out_valid <= 1'b1;
            out_sum   <= sum;
            out_last  <= last_word;
            out_carry <= last_word ? carry_out : 1'b0;
            out_ovf   <= last_word ? ovf : 1'b0;
            carry_reg <= carry_out;
            sub_reg   <= sub_eff;
            if (last_word) begin
                idx   <= '0;
                state <= IDLE;
                busy  <= 1'b0;
            end else begin
                idx   <= idx + 1'b1;
                state <= RUN;
                busy  <= 1'b1;
            end
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_multiword_add_seq.sv
// Directed self-checking bench for multiword_add_seq with WORDS=2.
module tb_multiword_add_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic        in_sub;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_sum;
    logic        out_last;
    logic        out_carry;
    logic        out_ovf;
    logic        busy;

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    multiword_add_seq #(
        .DATA_WIDTH(32),
        .WORDS     (2)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_a     (in_a),
        .in_b     (in_b),
        .in_sub   (in_sub),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_sum  (out_sum),
        .out_last (out_last),
        .out_carry(out_carry),
        .out_ovf  (out_ovf),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Present one pair with out_ready=1, then check the registered result.
    task automatic do_word(input string tag, input logic [31:0] a, input logic [31:0] b,
                           input logic sub, input logic [31:0] e_sum, input logic e_last,
                           input logic e_carry, input logic e_ovf);
        @(negedge clk);
        in_a = a; in_b = b; in_sub = sub; in_valid = 1'b1;
        check({tag, ".ready"}, 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check({tag, ".valid"}, 64'(out_valid), 64'd1);
        check({tag, ".sum"},   64'(out_sum),   64'(e_sum));
        check({tag, ".last"},  64'(out_last),  64'(e_last));
        check({tag, ".carry"}, 64'(out_carry), 64'(e_carry));
        check({tag, ".ovf"},   64'(out_ovf),   64'(e_ovf));
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; in_sub = 1'b0; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst.valid", 64'(out_valid), 64'd0);
        check("rst.sum",   64'(out_sum),   64'd0);
        check("rst.busy",  64'(busy),      64'd0);
        check("rst.ready", 64'(in_ready),  64'd1);
        @(negedge clk);
        rst_n = 1'b1;

        // Carry from LSW into MSW, back-to-back words
        do_word("add1.w0", 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b0, 1'b0, 1'b0);
        check("add1.busy", 64'(busy), 64'd1);
        do_word("add1.w1", 32'h0000_0000, 32'h0000_0000, 1'b0, 32'h0000_0001, 1'b1, 1'b0, 1'b0);
        check("add1.idle", 64'(busy), 64'd0);

        // Full-width carry out
        do_word("add2.w0", 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b0, 1'b0, 1'b0);
        do_word("add2.w1", 32'hFFFF_FFFF, 32'h0000_0000, 1'b0, 32'h0000_0000, 1'b1, 1'b1, 1'b0);

        // 0 - 1, in_sub only on word 0
        do_word("sub.w0", 32'h0000_0000, 32'h0000_0001, 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0);
        do_word("sub.w1", 32'h0000_0000, 32'h0000_0000, 1'b0, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0);

        // Signed overflow
        do_word("ovf.w0", 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b0, 1'b0, 1'b0);
        do_word("ovf.w1", 32'h7FFF_FFFF, 32'h0000_0000, 1'b0, 32'h8000_0000, 1'b1, 1'b0, 1'b1);

        // Let the output register drain
        @(posedge clk);
        #1;
        check("drain.valid", 64'(out_valid), 64'd0);

        // Backpressure: word 1 held while out_ready=0
        @(negedge clk);
        out_ready = 1'b0;
        in_a = 32'd5; in_b = 32'd3; in_sub = 1'b0; in_valid = 1'b1;
        check("bp.w0.ready", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;
        in_a = 32'd1; in_b = 32'd2;
        check("bp.w0.sum", 64'(out_sum), 64'd8);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("bp.hold.ready", 64'(in_ready),  64'd0);
            check("bp.hold.valid", 64'(out_valid), 64'd1);
            check("bp.hold.sum",   64'(out_sum),   64'd8);
            check("bp.hold.last",  64'(out_last),  64'd0);
        end
        out_ready = 1'b1;
        #1;
        check("bp.release.ready", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("bp.w1.valid", 64'(out_valid), 64'd1);
        check("bp.w1.sum",   64'(out_sum),   64'd3);
        check("bp.w1.last",  64'(out_last),  64'd1);
        @(posedge clk);
        #1;
        check("bp.after.valid", 64'(out_valid), 64'd0);
        check("bp.after.busy",  64'(busy),      64'd0);

        // Reset after word 0 leaves a pending carry
        do_word("rst.w0", 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst.valid", 64'(out_valid), 64'd0);
        check("midrst.sum",   64'(out_sum),   64'd0);
        check("midrst.busy",  64'(busy),      64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        do_word("post.w0", 32'd10, 32'd3, 1'b0, 32'd13, 1'b0, 1'b0, 1'b0);
        do_word("post.w1", 32'd0,  32'd0, 1'b0, 32'd0,  1'b1, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
